// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit ALU and the sequencer that drives it:
// datapath widths, op-code encodings, flag bit positions, the sequencer FSM
// state encoding, the instruction holding-register layout and a small helper
// that tells whether an op writes its result back to the register file.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int OP_W     = 3;
    localparam int FLAG_W   = 4;
    localparam int NUM_REGS = 8;

    // Op-code encodings, shared with the ALU itself.
    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_OR   = 3'b010;
    localparam logic [OP_W-1:0] OP_AND  = 3'b011;
    localparam logic [OP_W-1:0] OP_NOT  = 3'b100;
    localparam logic [OP_W-1:0] OP_COMP = 3'b101;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b110;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b111;

    // Flag vector layout {C, N, O, Z}.
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_O = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } seq_state_e;

    // One instruction as captured at accept time.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } hold_t;

    // Compare only produces flags; every other op writes its result back.
    function automatic logic op_writes_back(input logic [OP_W-1:0] op);
        return (op != OP_COMP);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// 8 x 8 register file behind the ALU sequencer. One synchronous write port,
// two combinational operand read ports (A and B) and one combinational debug
// read port. Synchronous active-high reset clears every entry to zero. There
// is no hardwired-zero register; all eight entries are writable.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset, clears all entries
//   we_i       write enable
//   waddr_i    write address
//   wdata_i    write data
//   ra_addr_i  A-operand read address   -> ra_data_o (combinational)
//   rb_addr_i  B-operand read address   -> rb_data_o (combinational)
//   rd_addr_i  debug read address       -> rd_data_o (combinational)
// ---------------------------------------------------------------------------
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [ADDR_W-1:0] rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;

    // One-hot write select, one bit per entry.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = we_i && (waddr_i == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= wdata_i;
                end
            end
        end
    end

    // Reads are combinational: a same-edge write is visible only after the edge.
    assign ra_data_o = regs_q[ra_addr_i];
    assign rb_data_o = regs_q[rb_addr_i];
    assign rd_data_o = regs_q[rd_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Issue/writeback controller in front of the 8-bit ALU. Accepts one
// register-level instruction at a time (valid/ready), reads its operands
// from the internal register file, presents them to the ALU for its
// one-cycle registered latency, then writes the result back and latches the
// ALU flags.
//
//   IDLE    : in_ready=1; on accept capture op, dst, A and B.
//   ISSUE   : drive operands/op, output enable low; ALU samples at the end.
//   CAPTURE : hold operands/op (C and O are combinational in the ALU),
//             output enable high; at the end latch flags, write back
//             (except compare), pulse out_done, return to IDLE.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      instruction handshake
//   in_op, in_dst, in_src    op code, destination (also A source), B source
//   in_use_imm, in_imm       select immediate B operand
//   alu_A, alu_B, alu_op     operands and op to the ALU
//   alu_enable_out           ALU output enable (high only in CAPTURE)
//   alu_result, alu_flags    ALU result and {C,N,O,Z} flags
//   out_flags                latched flags
//   out_done                 one-cycle pulse after writeback
//   in_rd_addr / out_rd_data debug read port (combinational)
// ---------------------------------------------------------------------------
module alu_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic [ADDR_W-1:0] in_src,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_enable_out,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [FLAG_W-1:0] out_flags,
    output logic              out_done,
    input  logic [ADDR_W-1:0] in_rd_addr,
    output logic [DATA_W-1:0] out_rd_data
);

    seq_state_e        state_q, state_d;
    hold_t             hold_q,  hold_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              done_q,  done_d;

    logic              rf_we;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;

    // Register file: A comes from the destination register, B from src.
    alu_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (rf_we),
        .waddr_i   (hold_q.dst),
        .wdata_i   (alu_result),
        .ra_addr_i (in_dst),
        .ra_data_o (ra_data),
        .rb_addr_i (in_src),
        .rb_data_o (rb_data),
        .rd_addr_i (in_rd_addr),
        .rd_data_o (out_rd_data)
    );

    // State and holding registers. Reset wins over a simultaneous accept and
    // aborts an in-flight instruction; the register file is cleared by the
    // same reset, so no writeback can slip through.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    // Next-state and outputs.
    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        flags_d        = flags_q;
        done_d         = 1'b0;
        in_ready       = 1'b0;
        alu_enable_out = 1'b0;
        rf_we          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_d.op  = in_op;
                    hold_d.dst = in_dst;
                    hold_d.a   = ra_data;
                    hold_d.b   = in_use_imm ? in_imm : rb_data;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                alu_enable_out = 1'b1;
                flags_d        = alu_flags;
                done_d         = 1'b1;
                rf_we          = op_writes_back(hold_q.op);
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operands stay on the ALU inputs between instructions so its outputs
    // keep their last values while the bus is released in IDLE.
    assign alu_A     = hold_q.a;
    assign alu_B     = hold_q.b;
    assign alu_op    = hold_q.op;
    assign out_flags = flags_q;
    assign out_done  = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer. A behavioural ALU (registered
// result/N/Z, combinational C/O) is attached to the ALU side. Accepted
// instructions are pushed onto a scoreboard with their expected operands,
// result and flags (from a shadow register file); entries are popped and
// compared when out_done pulses.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [2:0] in_dst;
    logic [2:0] in_src;
    logic       in_use_imm;
    logic [7:0] in_imm;
    logic [7:0] alu_A;
    logic [7:0] alu_B;
    logic [2:0] alu_op;
    logic       alu_enable_out;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic [3:0] out_flags;
    logic       out_done;
    logic [2:0] in_rd_addr;
    logic [7:0] out_rd_data;

    always #10 clk = ~clk;

    alu_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_dst         (in_dst),
        .in_src         (in_src),
        .in_use_imm     (in_use_imm),
        .in_imm         (in_imm),
        .alu_A          (alu_A),
        .alu_B          (alu_B),
        .alu_op         (alu_op),
        .alu_enable_out (alu_enable_out),
        .alu_result     (alu_result),
        .alu_flags      (alu_flags),
        .out_flags      (out_flags),
        .out_done       (out_done),
        .in_rd_addr     (in_rd_addr),
        .out_rd_data    (out_rd_data)
    );

    // Reference ALU: returns {result[7:0], C, N, O, Z}.
    function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        logic       o;
        c = 1'b0;
        o = 1'b0;
        r = 8'h00;
        w = 9'h000;
        case (op)
            3'b000: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0];
                c = w[8];
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'b001: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[7:0];
                c = w[8];
                o = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'b010: r = a | b;
            3'b011: r = a & b;
            3'b100: r = ~a;
            3'b101: r = (a == b) ? 8'h01 : 8'h00;
            3'b110: r = a >> 1;
            default: r = a << 1;
        endcase
        return {r, c, r[7], o, (r == 8'h00)};
    endfunction

    // Behavioural ALU on the driven side.
    logic [11:0] alu_comb;
    logic [7:0]  alu_res_q;
    logic        alu_n_q;
    logic        alu_z_q;
    assign alu_comb = ref_alu(alu_A, alu_B, alu_op);
    always @(posedge clk) begin
        alu_res_q <= alu_comb[11:4];
        alu_n_q   <= alu_comb[2];
        alu_z_q   <= alu_comb[0];
    end
    assign alu_result = alu_enable_out ? alu_res_q : 8'h00;
    assign alu_flags  = {alu_comb[3], alu_n_q, alu_comb[1], alu_z_q};

    typedef struct {
        logic [2:0] op;
        logic [2:0] dst;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flags;
        int         acc;
    } txn_t;

    txn_t       sb[$];
    logic [7:0] shadow [8];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = -100;
    bit         hold_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: detect accept, advance, then check cycle-level behaviour.
    task automatic step(output bit accepted);
        bit         acc_now;
        bit         rst_now;
        bit         exp_done;
        int         d;
        txn_t       t;
        logic [11:0] r;
        acc_now = in_valid && in_ready && !rst;
        rst_now = rst;
        if (acc_now) begin
            t.op  = in_op;
            t.dst = in_dst;
            t.a   = shadow[in_dst];
            t.b   = in_use_imm ? in_imm : shadow[in_src];
            r     = ref_alu(t.a, t.b, t.op);
            t.res   = r[11:4];
            t.flags = r[3:0];
        end
        @(posedge clk);
        #1;
        cyc++;
        accepted = acc_now;
        if (rst_now) begin
            sb.delete();
            for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
            acc_cyc = -100;
        end else if (acc_now) begin
            if (hold_mode && acc_cyc >= 0) check("accept_spacing", 32'(cyc - acc_cyc), 32'd3);
            t.acc = cyc;
            sb.push_back(t);
            if (t.op != 3'b101) shadow[t.dst] = t.res;
            acc_cyc = cyc;
        end
        d = cyc - acc_cyc;
        check("in_ready", {31'd0, in_ready}, {31'd0, !(d == 0 || d == 1)});
        check("alu_enable_out", {31'd0, alu_enable_out}, {31'd0, (d == 1)});
        if ((d == 0 || d == 1) && sb.size() > 0) begin
            check("alu_A", {24'd0, alu_A}, {24'd0, sb[0].a});
            check("alu_B", {24'd0, alu_B}, {24'd0, sb[0].b});
            check("alu_op", {29'd0, alu_op}, {29'd0, sb[0].op});
        end
        exp_done = (sb.size() > 0) && (cyc == sb[0].acc + 2);
        check("out_done", {31'd0, out_done}, {31'd0, exp_done});
        if (out_done && exp_done) begin
            t = sb.pop_front();
            check("out_flags", {28'd0, out_flags}, {28'd0, t.flags});
            in_rd_addr = t.dst;
            #1;
            check("writeback", {24'd0, out_rd_data}, {24'd0, shadow[t.dst]});
            $display("txn op=%0d dst=r%0d A=%02h B=%02h res=%02h flags=%04b rd=%02h",
                     t.op, t.dst, t.a, t.b, t.res, out_flags, out_rd_data);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                         input logic use_imm, input logic [7:0] imm);
        bit a;
        bit got;
        got = 1'b0;
        in_op      = op;
        in_dst     = dst;
        in_src     = src;
        in_use_imm = use_imm;
        in_imm     = imm;
        in_valid   = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            step(a);
            got = a;
            if (got) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 8 && sb.size() > 0; i++) step(a);
        if (sb.size() > 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic read_reg(input logic [2:0] addr, output logic [7:0] val);
        in_rd_addr = addr;
        #1;
        val = out_rd_data;
    endtask

    task automatic check_reset_state(input string tag);
        logic [7:0] v;
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_done"}, {31'd0, out_done}, 32'd0);
        check({tag, "_flags"}, {28'd0, out_flags}, 32'd0);
        check({tag, "_enable"}, {31'd0, alu_enable_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v);
            check({tag, "_reg"}, {24'd0, v}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         a;
        int         n;
        logic [7:0] v;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op      = 3'b000;
        in_dst     = 3'd0;
        in_src     = 3'd0;
        in_use_imm = 1'b0;
        in_imm     = 8'h00;
        in_rd_addr = 3'd0;
        for (int i = 0; i < 8; i++) shadow[i] = 8'h00;

        for (int i = 0; i < 3; i++) step(a);
        rst = 1'b0;
        check_reset_state("reset");
        check("reset_alu_A", {24'd0, alu_A}, 32'd0);
        check("reset_alu_B", {24'd0, alu_B}, 32'd0);
        check("reset_alu_op", {29'd0, alu_op}, 32'd0);

        // ADD r1(7F) + 01 -> 80, N and O set.
        issue(3'b010, 3'd1, 3'd0, 1'b1, 8'h7F);
        issue(3'b000, 3'd1, 3'd0, 1'b1, 8'h01);
        read_reg(3'd1, v);
        check("add_r1", {24'd0, v}, 32'h80);
        check("add_flags", {28'd0, out_flags}, 32'b0110);

        // SUB r2(00) - r3(01) -> FF, C and N set.
        issue(3'b010, 3'd3, 3'd0, 1'b1, 8'h01);
        issue(3'b001, 3'd2, 3'd3, 1'b0, 8'h00);
        read_reg(3'd2, v);
        check("sub_r2", {24'd0, v}, 32'hFF);
        check("sub_flags", {28'd0, out_flags}, 32'b1100);

        // COMP r4(05) with 05 -> no writeback, flags clear.
        issue(3'b010, 3'd4, 3'd0, 1'b1, 8'h05);
        issue(3'b101, 3'd4, 3'd0, 1'b1, 8'h05);
        read_reg(3'd4, v);
        check("comp_r4", {24'd0, v}, 32'h05);
        check("comp_flags", {28'd0, out_flags}, 32'b0000);

        // SHL r5(81) -> 02, carry not reported for shifts.
        issue(3'b010, 3'd5, 3'd0, 1'b1, 8'h81);
        issue(3'b111, 3'd5, 3'd0, 1'b0, 8'h00);
        read_reg(3'd5, v);
        check("shl_r5", {24'd0, v}, 32'h02);
        check("shl_flags", {28'd0, out_flags}, 32'b0000);

        // Mixed traffic over all ops and register/immediate sources.
        for (int i = 0; i < 12; i++) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)));
        end

        // in_valid held high: accepts exactly every third cycle.
        hold_mode  = 1'b1;
        n          = 0;
        in_op      = 3'b000;
        in_dst     = 3'd6;
        in_src     = 3'd0;
        in_use_imm = 1'b1;
        in_imm     = 8'h01;
        in_valid   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(a);
            if (a) n++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step(a);
        hold_mode = 1'b0;
        check("b2b_accepts", 32'(n), 32'd4);
        check("b2b_drained", 32'(sb.size()), 32'd0);

        // Make flags nonzero, then abort an ADD with reset during CAPTURE.
        issue(3'b001, 3'd7, 3'd7, 1'b1, 8'h01);
        check("pre_abort_flags", {28'd0, out_flags}, 32'b1100);
        in_op      = 3'b000;
        in_dst     = 3'd1;
        in_src     = 3'd0;
        in_use_imm = 1'b1;
        in_imm     = 8'h10;
        in_valid   = 1'b1;
        step(a);
        in_valid = 1'b0;
        check("abort_accepted", {31'd0, a}, 32'd1);
        step(a);
        rst = 1'b1;
        step(a);
        rst = 1'b0;
        check_reset_state("abort");

        // Reset takes priority over a simultaneous accept.
        rst      = 1'b1;
        in_valid = 1'b1;
        step(a);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step(a);
        check("rst_priority_no_txn", 32'(sb.size()), 32'd0);
        read_reg(3'd1, v);
        check("rst_priority_r1", {24'd0, v}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
